// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds whole packets from NREQ byte requesters into a UART transmitter's register bus.
// A grant is held for the full packet; the transmitter is polled for TXFULL before every byte is written.
module uart_tx_arbiter #(
  parameter logic [7:0] PERIOD = 8'h1A,
  parameter int         NREQ   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   last,
  input  logic [8*NREQ-1:0] data,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic [15:0]       bytes_sent,
  output logic              bus_wren,
  output logic              bus_rden,
  output logic [2:0]        bus_addr,
  output logic [7:0]        bus_din,
  input  logic [7:0]        bus_dout
);

  localparam int IW = $clog2(NREQ);

  localparam logic [2:0] ADDR_PERIOD = 3'b000;
  localparam logic [2:0] ADDR_TXDATA = 3'b001;
  localparam logic [2:0] ADDR_CTRL   = 3'b011;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_POLL,
    S_WRITE,
    S_SETTLE
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [15:0]     bytes_q, bytes_d;
  logic            settle_q, settle_d;

  logic            rr_found;
  logic [IW-1:0]   rr_idx;
  logic [IW-1:0]   rr_cand;
  logic [7:0]      lane;

  logic            wren_c, rden_c;
  logic [2:0]      addr_c;
  logic [7:0]      din_c;
  logic [NREQ-1:0] ack_c;

  // Only TXFULL is used from the control register read.
  logic            unused_dout;
  assign unused_dout = ^bus_dout[7:1];

  // Search begins one past the last-served requester.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    rr_cand  = ptr_q;
    for (int k = 1; k <= NREQ; k++) begin
      rr_cand = IW'((int'(ptr_q) + k) % NREQ);
      if (!rr_found && req[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  assign lane = data[gidx_q*8 +: 8];

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gidx_d   = gidx_q;
    ptr_d    = ptr_q;
    bytes_d  = bytes_q;
    settle_d = settle_q;
    wren_c   = 1'b0;
    rden_c   = 1'b0;
    addr_c   = ADDR_PERIOD;
    din_c    = 8'h00;
    ack_c    = '0;
    case (state_q)
      S_INIT: begin
        wren_c  = 1'b1;
        addr_c  = ADDR_PERIOD;
        din_c   = PERIOD;
        state_d = S_IDLE;
      end
      S_IDLE: begin
        if (rr_found) begin
          gnt_d   = NREQ'(1) << rr_idx;
          gidx_d  = rr_idx;
          state_d = S_POLL;
        end
      end
      S_POLL: begin
        rden_c = 1'b1;
        addr_c = ADDR_CTRL;
        if (!req[gidx_q]) begin
          gnt_d   = '0;
          ptr_d   = gidx_q;
          state_d = S_IDLE;
        end else if (!bus_dout[0]) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        wren_c  = 1'b1;
        addr_c  = ADDR_TXDATA;
        din_c   = lane;
        ack_c   = gnt_q;
        bytes_d = bytes_q + 16'd1;
        if (last[gidx_q]) begin
          gnt_d   = '0;
          ptr_d   = gidx_q;
          state_d = S_IDLE;
        end else begin
          settle_d = 1'b0;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // Two idle cycles let TXFULL catch up with the byte just written.
        if (settle_q) begin
          settle_d = 1'b0;
          state_d  = S_POLL;
        end else begin
          settle_d = 1'b1;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_INIT;
      gnt_q    <= '0;
      gidx_q   <= '0;
      ptr_q    <= IW'(NREQ - 1);
      bytes_q  <= 16'h0000;
      settle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gidx_q   <= gidx_d;
      ptr_q    <= ptr_d;
      bytes_q  <= bytes_d;
      settle_q <= settle_d;
    end
  end

  // The INIT decode is masked while reset is held so the bus stays quiet.
  assign bus_wren   = wren_c & ~reset;
  assign bus_rden   = rden_c & ~reset;
  assign bus_addr   = reset ? 3'b000 : addr_c;
  assign bus_din    = reset ? 8'h00 : din_c;
  assign ack        = reset ? '0 : ack_c;
  assign gnt        = gnt_q;
  assign busy       = (state_q != S_IDLE);
  assign bytes_sent = bytes_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: init write, single/multi-byte packets, round-robin order,
// TXFULL stall, mid-packet abort, mid-packet reset and byte-counter wrap.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, last;
  logic [31:0] data;
  logic [3:0]  ack, gnt;
  logic        busy;
  logic [15:0] bytes_sent;
  logic        bus_wren, bus_rden;
  logic [2:0]  bus_addr;
  logic [7:0]  bus_din;
  logic [7:0]  bus_dout;

  int compared   = 0;
  int mismatched = 0;

  uart_tx_arbiter #(.PERIOD(8'h1A), .NREQ(4)) dut (
    .clk(clk), .reset(reset), .req(req), .last(last), .data(data),
    .ack(ack), .gnt(gnt), .busy(busy), .bytes_sent(bytes_sent),
    .bus_wren(bus_wren), .bus_rden(bus_rden), .bus_addr(bus_addr),
    .bus_din(bus_din), .bus_dout(bus_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] rr_gnt [5];
    logic [7:0] rr_din [5];
    rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_din = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    reset = 1'b1; req = '0; last = '0; data = '0; bus_dout = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_ack", ack, 4'b0000);
    chk("rst_bytes", bytes_sent, 16'h0000);
    chk("rst_wren", bus_wren, 1'b0);
    chk("rst_din", bus_din, 8'h00);

    // Release reset: INIT writes the period register for one cycle.
    reset = 1'b0;
    #1;
    chk("init_wren", bus_wren, 1'b1);
    chk("init_addr", bus_addr, 3'b000);
    chk("init_din", bus_din, 8'h1A);
    step();
    chk("idle_busy", busy, 1'b0);
    chk("idle_strobes", {bus_wren, bus_rden}, 2'b00);
    chk("idle_din", bus_din, 8'h00);

    // Single-byte packet from requester 0.
    req = 4'b0001; last = 4'b0001; data = 32'h0000_0055;
    step();
    chk("p0_gnt", gnt, 4'b0001);
    chk("p0_poll", {bus_rden, bus_wren, bus_addr}, {1'b1, 1'b0, 3'b011});
    step();
    chk("p0_write", {bus_wren, bus_rden, bus_addr}, {1'b1, 1'b0, 3'b001});
    chk("p0_din", bus_din, 8'h55);
    chk("p0_ack", ack, 4'b0001);
    step();
    chk("p0_idle_gnt", gnt, 4'b0000);
    chk("p0_bytes", bytes_sent, 16'd1);
    req = '0; last = '0;

    // Reset in the middle of a packet aborts it and re-runs INIT.
    req = 4'b0100; data = 32'h0077_0000;
    step();
    chk("mr_gnt", gnt, 4'b0100);
    step();
    chk("mr_ack", ack, 4'b0100);
    step();
    chk("mr_settle", {ack, bus_wren, bus_rden, bus_addr}, {4'b0000, 1'b0, 1'b0, 3'b000});
    reset = 1'b1; req = '0;
    #1;
    chk("mr_rst_gnt", gnt, 4'b0000);
    chk("mr_rst_bytes", bytes_sent, 16'h0000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("mr_init", {bus_wren, bus_addr, bus_din}, {1'b1, 3'b000, 8'h1A});
    step();
    chk("mr_idle", busy, 1'b0);

    // All four request single-byte packets: pointer back at 3, so order 0,1,2,3,0.
    req = 4'b1111; last = 4'b1111; data = 32'h4433_2211;
    for (int r = 0; r < 5; r++) begin
      step();
      chk($sformatf("rr%0d_gnt", r), gnt, rr_gnt[r]);
      step();
      chk($sformatf("rr%0d_ack", r), ack, rr_gnt[r]);
      chk($sformatf("rr%0d_din", r), bus_din, rr_din[r]);
      step();
      chk($sformatf("rr%0d_idle", r), {busy, gnt}, {1'b0, 4'b0000});
    end
    req = '0; last = '0;
    chk("rr_bytes", bytes_sent, 16'd5);

    // Requester 2 sends three bytes while requester 0 waits; no preemption.
    req = 4'b0101; last = 4'b0000; data = 32'h00C1_005A;
    step();
    chk("m_gnt", gnt, 4'b0100);
    step();
    chk("m_b1", {ack, bus_din}, {4'b0100, 8'hC1});
    step();
    chk("m_s1a", ack, 4'b0000);
    data = 32'h00C2_005A;
    step();
    chk("m_s1b", {ack, bus_wren, bus_rden}, {4'b0000, 1'b0, 1'b0});
    step();
    chk("m_p2", {ack, bus_rden, gnt}, {4'b0000, 1'b1, 4'b0100});
    step();
    chk("m_b2", {ack, bus_din}, {4'b0100, 8'hC2});
    step();
    data = 32'h00C3_005A; last = 4'b0100;
    step();
    step();
    chk("m_p3", {ack, bus_rden}, {4'b0000, 1'b1});
    step();
    chk("m_b3", {ack, bus_din}, {4'b0100, 8'hC3});
    step();
    chk("m_idle", gnt, 4'b0000);
    req = 4'b0001; last = 4'b0001;
    step();
    chk("m_next_gnt", gnt, 4'b0001);

    // TXFULL held for 20 cycles stalls in POLL.
    bus_dout = 8'h01;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("full%0d", i), {bus_rden, bus_wren, ack}, {1'b1, 1'b0, 4'b0000});
    end
    bus_dout = 8'h00;
    step();
    chk("full_write", {ack, bus_din}, {4'b0001, 8'h5A});
    step();
    req = '0; last = '0;
    chk("full_bytes", bytes_sent, 16'd9);

    // Requester 1 drops req mid-packet: abort without ack, pointer moves to 1.
    req = 4'b0010; data = 32'h0000_9900;
    step();
    chk("ab_gnt", gnt, 4'b0010);
    step();
    chk("ab_ack1", ack, 4'b0010);
    step();
    req = 4'b0000;
    step();
    step();
    chk("ab_poll", {bus_rden, gnt}, {1'b1, 4'b0010});
    step();
    chk("ab_idle", {busy, gnt, ack}, {1'b0, 4'b0000, 4'b0000});
    chk("ab_bytes", bytes_sent, 16'd10);
    req = 4'b1111; last = 4'b1111;
    step();
    chk("ab_ptr", gnt, 4'b0100);
    step();
    step();
    req = '0; last = '0;
    chk("ab_bytes2", bytes_sent, 16'd11);

    // Byte counter wraps from FFFF to 0.
    force dut.bytes_q = 16'hFFFF;
    step();
    release dut.bytes_q;
    chk("wrap_pre", bytes_sent, 16'hFFFF);
    req = 4'b0001; last = 4'b0001; data = 32'h0000_00E7;
    step();
    step();
    chk("wrap_ack", ack, 4'b0001);
    step();
    req = '0; last = '0;
    chk("wrap_bytes", bytes_sent, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
